// File: rtl/conv3x3_engine.sv
// rtl/conv3x3_engine.sv - 3x3 convolution engine, four kernels, 3-stage MAC pipeline
//
// Purpose: loads four signed 3x3 kernels from an upstream loader, then streams
// unsigned 3x3 pixel windows through a 3-stage pipeline
// (products -> row sums -> final sums).
// The engine produces four signed dot products per window.
//
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   start, num_windows      job request and number of windows in the job
//   busy, done              job in progress / one-cycle completion pulse
//   load_start, load_end    weight-load request pulse / loader completion pulse
//   weight0..weight3        kernels, element 0 in the MSB lane
//   window                  pixel window, same lane ordering as the weights
//   win_valid, win_ready    window handshake
//   conv_valid, out_ready   result handshake
//   conv_out0..conv_out3    results, OUT_WIDTH-bit signed
//
// Compile-time option: CONV3X3_RELU_EN clamps negative results to zero in stage 3.
module conv3x3_engine #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int PIXEL_WIDTH  = 8,
  parameter int CNT_WIDTH    = 16,
  localparam int OUT_WIDTH   = WEIGHT_WIDTH + PIXEL_WIDTH + 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      num_windows,
  output logic                      busy,
  output logic                      done,
  output logic                      load_start,
  input  logic                      load_end,
  input  logic [9*WEIGHT_WIDTH-1:0] weight0,
  input  logic [9*WEIGHT_WIDTH-1:0] weight1,
  input  logic [9*WEIGHT_WIDTH-1:0] weight2,
  input  logic [9*WEIGHT_WIDTH-1:0] weight3,
  input  logic [9*PIXEL_WIDTH-1:0]  window,
  input  logic                      win_valid,
  output logic                      win_ready,
  output logic                      conv_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      conv_out0,
  output logic [OUT_WIDTH-1:0]      conv_out1,
  output logic [OUT_WIDTH-1:0]      conv_out2,
  output logic [OUT_WIDTH-1:0]      conv_out3
);

  // Product of a zero-extended pixel and a signed weight; two guard bits per
  // adder level keep the row sums and the final sum overflow-free.
  localparam int PROD_WIDTH = WEIGHT_WIDTH + PIXEL_WIDTH + 1;
  localparam int ROW_WIDTH  = PROD_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t                     state;
  logic [CNT_WIDTH-1:0]       remaining;
  logic [9*WEIGHT_WIDTH-1:0]  w_q [4];

  logic                        v1, v2;
  logic signed [PROD_WIDTH-1:0] prod_d [4][9];
  logic signed [PROD_WIDTH-1:0] prod_q [4][9];
  logic signed [ROW_WIDTH-1:0]  row_d  [4][3];
  logic signed [ROW_WIDTH-1:0]  row_q  [4][3];
  logic [OUT_WIDTH-1:0]         fin_d  [4];

  logic stall, xfer, drained;

  assign stall     = conv_valid & ~out_ready;
  assign win_ready = (state == RUN) && (remaining != '0) && !stall;
  assign xfer      = win_valid & win_ready;
  // The pipeline is empty next cycle if stages 1/2 are empty and the result
  // stage is either empty or being consumed now.
  assign drained   = !v1 && !v2 && (!conv_valid || out_ready);

  function automatic logic signed [PROD_WIDTH-1:0] mul_elem(
    input logic [PIXEL_WIDTH-1:0]  p,
    input logic [WEIGHT_WIDTH-1:0] w
  );
    logic signed [PROD_WIDTH-1:0] pe;
    logic signed [PROD_WIDTH-1:0] we;
    pe = $signed({{(PROD_WIDTH-PIXEL_WIDTH){1'b0}}, p});
    we = $signed({{(PROD_WIDTH-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w});
    return pe * we;
  endfunction

  function automatic logic signed [ROW_WIDTH-1:0] ext_prod(input logic signed [PROD_WIDTH-1:0] p);
    return $signed({{2{p[PROD_WIDTH-1]}}, p});
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] ext_row(input logic signed [ROW_WIDTH-1:0] r);
    return $signed({{(OUT_WIDTH-ROW_WIDTH){r[ROW_WIDTH-1]}}, r});
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      for (int e = 0; e < 9; e++) begin
        prod_d[k][e] = mul_elem(window[(8-e)*PIXEL_WIDTH +: PIXEL_WIDTH],
                                w_q[k][(8-e)*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 3; r++) begin
        row_d[k][r] = ext_prod(prod_q[k][3*r]) + ext_prod(prod_q[k][3*r+1])
                    + ext_prod(prod_q[k][3*r+2]);
      end
    end
  end

  always_comb begin
    logic signed [OUT_WIDTH-1:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      s = ext_row(row_q[k][0]) + ext_row(row_q[k][1]) + ext_row(row_q[k][2]);
`ifdef CONV3X3_RELU_EN
      fin_d[k] = s[OUT_WIDTH-1] ? '0 : s;
`else
      fin_d[k] = s;
`endif
    end
  end

  // Control FSM: job sequencing, weight capture and the window countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_start <= 1'b0;
      for (int k = 0; k < 4; k++) w_q[k] <= '0;
    end else begin
      done       <= 1'b0;
      load_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining  <= num_windows;
            load_start <= 1'b1;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (load_end) begin
            w_q[0] <= weight0;
            w_q[1] <= weight1;
            w_q[2] <= weight2;
            w_q[3] <= weight3;
            state  <= RUN;
          end
        end
        RUN: begin
          if (xfer) remaining <= remaining - CNT_ONE;
          if ((remaining == '0) || (xfer && remaining == CNT_ONE)) state <= DRAIN;
        end
        DRAIN: begin
          if (drained) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: a stall freezes every stage; each stage loads only when valid
  // data arrives so results stay put between transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      conv_valid <= 1'b0;
      conv_out0  <= '0;
      conv_out1  <= '0;
      conv_out2  <= '0;
      conv_out3  <= '0;
      for (int k = 0; k < 4; k++) begin
        for (int e = 0; e < 9; e++) prod_q[k][e] <= '0;
        for (int r = 0; r < 3; r++) row_q[k][r] <= '0;
      end
    end else if (!stall) begin
      v1         <= xfer;
      v2         <= v1;
      conv_valid <= v2;
      if (xfer) prod_q <= prod_d;
      if (v1)   row_q  <= row_d;
      if (v2) begin
        conv_out0 <= fin_d[0];
        conv_out1 <= fin_d[1];
        conv_out2 <= fin_d[2];
        conv_out3 <= fin_d[3];
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// tb/tb_conv3x3_engine.sv - scoreboard testbench for conv3x3_engine
module tb_conv3x3_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_windows;
  logic        busy, done, load_start, load_end;
  logic [71:0] weight0, weight1, weight2, weight3;
  logic [71:0] window;
  logic        win_valid, win_ready, conv_valid, out_ready;
  logic [20:0] conv_out0, conv_out1, conv_out2, conv_out3;

  always #5 clk = ~clk;

  conv3x3_engine dut (
    .clk(clk), .rst(rst), .start(start), .num_windows(num_windows),
    .busy(busy), .done(done), .load_start(load_start), .load_end(load_end),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .window(window), .win_valid(win_valid), .win_ready(win_ready),
    .conv_valid(conv_valid), .out_ready(out_ready),
    .conv_out0(conv_out0), .conv_out1(conv_out1),
    .conv_out2(conv_out2), .conv_out3(conv_out3)
  );

  localparam logic [71:0] W_ONES = {9{8'h01}};
  localparam logic [71:0] W_NEG  = {9{8'hFF}};
  localparam logic [71:0] W_ZERO = 72'h0;
  localparam logic [71:0] W_MIX  = {8'h7F, 8'h80, 56'h0};
  localparam logic [71:0] WIN_2   = {9{8'h02}};
  localparam logic [71:0] WIN_255 = {9{8'hFF}};
  localparam logic [71:0] WIN_SEQ = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
  localparam logic [71:0] WIN_ROW = {8'd10, 8'd20, 8'd30, 48'h0};

  typedef struct {
    int o0, o1, o2, o3;
    int acc;
    bit lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rl(input int v);
`ifdef CONV3X3_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the head of the scoreboard whenever a result is presented;
  // pops it only when the result is actually taken.
  always @(negedge clk) begin
    if (!rst && conv_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q[0];
        chk("conv_out0", int'($signed(conv_out0)), e.o0);
        chk("conv_out1", int'($signed(conv_out1)), e.o1);
        chk("conv_out2", int'($signed(conv_out2)), e.o2);
        chk("conv_out3", int'($signed(conv_out3)), e.o3);
        if (out_ready) begin
          if (e.lat) chk("latency", cyc - e.acc, 3);
          e = exp_q.pop_front();
        end else begin
          chk("win_ready_in_stall", int'(win_ready), 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n);
    num_windows = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_start_pulse", int'(load_start), 1);
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic do_load(input logic [71:0] a, input logic [71:0] b,
                         input logic [71:0] c, input logic [71:0] d);
    tick();
    chk("load_start_one_cycle", int'(load_start), 0);
    weight0 = a; weight1 = b; weight2 = c; weight3 = d;
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    weight0 = W_ZERO; weight1 = W_ZERO; weight2 = W_ZERO; weight3 = W_ZERO;
  endtask

  task automatic send_window(input logic [71:0] w, input int e0, input int e1,
                             input int e2, input int e3, input bit lat);
    exp_t e;
    bit ok;
    ok = 1'b0;
    window = w;
    win_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (win_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("win_accept", int'(ok), 1);
    if (ok) begin
      e.o0 = rl(e0); e.o1 = rl(e1); e.o2 = rl(e2); e.o3 = rl(e3);
      e.acc = cyc;
      e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    win_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      chk({name, "_busy_low_at_done"}, int'(busy), 0);
      @(negedge clk);
      chk({name, "_done_one_cycle"}, int'(done), 0);
    end
    chk({name, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; num_windows = '0; load_end = 1'b0;
    weight0 = W_ZERO; weight1 = W_ZERO; weight2 = W_ZERO; weight3 = W_ZERO;
    window = '0; win_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_load_start", int'(load_start), 0);
    chk("rst_win_ready", int'(win_ready), 0);
    chk("rst_conv_valid", int'(conv_valid), 0);
    chk("rst_conv_out", int'(conv_out0 | conv_out1 | conv_out2 | conv_out3), 0);
    rst = 1'b0;
    tick();

    // Single window, all-ones kernels.
    start_job(1);
    do_load(W_ONES, W_ONES, W_ONES, W_ONES);
    send_window(WIN_2, 18, 18, 18, 18, 1'b1);
    wait_done("single");

    // Four back-to-back windows; a load_end during RUN must not disturb weights.
    start_job(4);
    do_load(W_NEG, W_ONES, W_ZERO, W_MIX);
    weight0 = W_ONES; weight1 = W_NEG; weight2 = W_ONES; weight3 = W_ONES;
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    send_window(WIN_255, -2295, 2295, 0, -255, 1'b1);
    send_window(WIN_SEQ, -45, 45, 0, -129, 1'b1);
    send_window(WIN_ROW, -60, 60, 0, -1290, 1'b1);
    send_window(WIN_2, -18, 18, 0, -2, 1'b1);
    wait_done("burst");

    // Backpressure: out_ready low for 5 cycles mid-stream.
    start_job(6);
    do_load(W_NEG, W_ONES, W_ZERO, W_MIX);
    fork
      begin
        send_window(WIN_SEQ, -45, 45, 0, -129, 1'b0);
        send_window(WIN_ROW, -60, 60, 0, -1290, 1'b0);
        send_window(WIN_2, -18, 18, 0, -2, 1'b0);
        send_window(WIN_255, -2295, 2295, 0, -255, 1'b0);
        send_window(WIN_SEQ, -45, 45, 0, -129, 1'b0);
        send_window(WIN_ROW, -60, 60, 0, -1290, 1'b0);
      end
      begin
        repeat (4) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
      end
    join
    wait_done("stall");

    // Zero-window job; a second start while busy is ignored.
    start_job(0);
    tick();
    chk("zero_load_start_one_cycle", int'(load_start), 0);
    num_windows = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_while_busy_no_load", int'(load_start), 0);
    weight0 = W_ONES; load_end = 1'b1;
    tick();
    load_end = 1'b0; weight0 = W_ZERO;
    found = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk("zero_done_within_3", int'(found), 1);
    repeat (4) tick();
    chk("zero_busy_stays_low", int'(busy), 0);
    chk("zero_no_new_load", int'(load_start), 0);

    // Reset mid-job with two results in flight.
    start_job(4);
    do_load(W_NEG, W_ONES, W_ZERO, W_MIX);
    send_window(WIN_SEQ, -45, 45, 0, -129, 1'b1);
    send_window(WIN_ROW, -60, 60, 0, -1290, 1'b1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_win_ready", int'(win_ready), 0);
    chk("abort_conv_valid", int'(conv_valid), 0);
    chk("abort_conv_out", int'(conv_out0 | conv_out1 | conv_out2 | conv_out3), 0);
    rst = 1'b0;
    tick();
    start_job(1);
    do_load(W_ONES, W_ONES, W_ONES, W_ONES);
    send_window(WIN_2, 18, 18, 18, 18, 1'b1);
    wait_done("after_abort");

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
